// File: rtl/slot_pkg.sv
// Shared types and constants for the slot-machine credit path.
package slot_pkg;

  localparam int SCORE_W  = 4;
  localparam int CREDIT_W = 7;
  localparam int BCD_W    = 4;

  localparam logic [SCORE_W-1:0] PAY_NONE   = 4'd0;
  localparam logic [SCORE_W-1:0] PAY_PAIR   = 4'd1;
  localparam logic [SCORE_W-1:0] PAY_TRIPLE = 4'd5;
  localparam logic [SCORE_W-1:0] PAY_QUAD   = 4'd10;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_CHARGE   = 3'd1,
    ST_SPINNING = 3'd2,
    ST_AWAIT    = 3'd3,
    ST_PAYOUT   = 3'd4,
    ST_OVER     = 3'd5
  } bank_state_t;

endpackage

// File: rtl/credit_bank_bcd_split.sv
// Combinational binary (0..99) to two-digit BCD; values above 99 report tens = 9.
module bcd_split
  import slot_pkg::*;
(
  input  logic [CREDIT_W-1:0] i_bin,
  output logic [BCD_W-1:0]    o_tens,
  output logic [BCD_W-1:0]    o_ones
);

  logic [BCD_W-1:0] w_tens;

  // Threshold compare chain instead of a divider: only ten possible tens values.
  always_comb begin
    w_tens = '0;
    for (int t = 1; t < 10; t++) begin
      if (i_bin >= CREDIT_W'(t * 10)) w_tens = BCD_W'(t);
    end
  end

  assign o_tens = w_tens;
  assign o_ones = BCD_W'(i_bin - (CREDIT_W'(w_tens) * CREDIT_W'(10)));

endmodule

// File: rtl/credit_bank.sv
// Player-credit controller: charges one spin per button press, holds the core's spin
// request, collects the score (or refunds on timeout) and shows the balance in BCD.
module credit_bank
  import slot_pkg::*;
#(
  parameter int START_CREDITS  = 10,
  parameter int MAX_CREDITS    = 99,
  parameter int SPIN_COST      = 1,
  parameter int SPIN_HOLD      = 4900,
  parameter int RESULT_TIMEOUT = 7000
) (
  input  logic                i_clk,
  input  logic                i_rst_n,
  input  logic                i_spin_btn,
  input  logic [SCORE_W-1:0]  i_score,
  input  logic                i_score_valid,
  output logic                o_spin,
  output logic [CREDIT_W-1:0] o_credits,
  output logic [BCD_W-1:0]    o_credits_tens,
  output logic [BCD_W-1:0]    o_credits_ones,
  output logic                o_busy,
  output logic                o_game_over
);

  localparam int CNT_MAX = (SPIN_HOLD > RESULT_TIMEOUT) ? SPIN_HOLD : RESULT_TIMEOUT;
  localparam int CNT_W   = (CNT_MAX < 2) ? 1 : $clog2(CNT_MAX);

  localparam logic [CREDIT_W-1:0] COST_C     = CREDIT_W'(SPIN_COST);
  localparam logic [CREDIT_W-1:0] MAX_C      = CREDIT_W'(MAX_CREDITS);
  localparam logic [CREDIT_W-1:0] START_C    = CREDIT_W'(START_CREDITS);
  localparam logic [BCD_W-1:0]    START_TENS = BCD_W'(START_CREDITS / 10);
  localparam logic [BCD_W-1:0]    START_ONES = BCD_W'(START_CREDITS % 10);
  localparam logic [CNT_W-1:0]    HOLD_LAST  = CNT_W'(SPIN_HOLD - 1);
  localparam logic [CNT_W-1:0]    TMO_LAST   = CNT_W'(RESULT_TIMEOUT - 1);

  // Add one bit wider than the balance so the ceiling compare never sees a wrapped sum.
  function automatic logic [CREDIT_W-1:0] sat_add(input logic [CREDIT_W-1:0] a,
                                                  input logic [CREDIT_W-1:0] b);
    logic [CREDIT_W:0] s;
    s = {1'b0, a} + {1'b0, b};
    if (s > {1'b0, MAX_C}) return MAX_C;
    return s[CREDIT_W-1:0];
  endfunction

  bank_state_t         r_state;
  bank_state_t         w_next;
  logic                r_sync1;
  logic                r_sync2;
  logic                r_prev;
  logic                w_press;
  logic [CREDIT_W-1:0] r_credits;
  logic [CNT_W-1:0]    r_cnt;
  logic                r_refund;
  logic [SCORE_W-1:0]  r_score;
  logic [CREDIT_W-1:0] w_pay;
  logic [CREDIT_W-1:0] w_paid;
  logic [BCD_W-1:0]    w_tens;
  logic [BCD_W-1:0]    w_ones;
  logic [BCD_W-1:0]    r_tens;
  logic [BCD_W-1:0]    r_ones;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
      r_prev  <= 1'b0;
    end else begin
      r_sync1 <= i_spin_btn;
      r_sync2 <= r_sync1;
      r_prev  <= r_sync2;
    end
  end

  assign w_press = r_sync2 & ~r_prev;
  assign w_pay   = r_refund ? COST_C : CREDIT_W'(r_score);
  assign w_paid  = sat_add(r_credits, w_pay);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_state <= ST_IDLE;
    else          r_state <= w_next;
  end

  always_comb begin
    w_next      = r_state;
    o_spin      = 1'b0;
    o_busy      = 1'b1;
    o_game_over = 1'b0;
    case (r_state)
      ST_IDLE: begin
        o_busy = 1'b0;
        if (w_press) w_next = (r_credits >= COST_C) ? ST_CHARGE : ST_OVER;
      end
      ST_CHARGE: w_next = ST_SPINNING;
      ST_SPINNING: begin
        o_spin = 1'b1;
        if (r_cnt == HOLD_LAST) w_next = ST_AWAIT;
      end
      ST_AWAIT: begin
        if (i_score_valid || (r_cnt == TMO_LAST)) w_next = ST_PAYOUT;
      end
      ST_PAYOUT: w_next = (w_paid < COST_C) ? ST_OVER : ST_IDLE;
      ST_OVER: begin
        o_busy      = 1'b0;
        o_game_over = 1'b1;
      end
      default: w_next = ST_IDLE;
    endcase
  end

  // One counter serves both the spin hold and the result timeout; it is
  // cleared on entry to each of those phases.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_credits <= START_C;
      r_cnt     <= '0;
      r_refund  <= 1'b0;
      r_tens    <= START_TENS;
      r_ones    <= START_ONES;
    end else begin
      r_tens <= w_tens;
      r_ones <= w_ones;
      case (r_state)
        ST_CHARGE: begin
          r_credits <= r_credits - COST_C;
          r_cnt     <= '0;
        end
        ST_SPINNING: r_cnt <= (r_cnt == HOLD_LAST) ? '0 : r_cnt + 1'b1;
        ST_AWAIT: begin
          r_cnt <= r_cnt + 1'b1;
          if (i_score_valid)          r_refund <= 1'b0;
          else if (r_cnt == TMO_LAST) r_refund <= 1'b1;
        end
        ST_PAYOUT: r_credits <= w_paid;
        default: ;
      endcase
    end
  end

  // Score capture needs no reset: it is always written in AWAIT before PAYOUT reads it.
  always_ff @(posedge i_clk) begin
    if (r_state == ST_AWAIT) begin
      if (i_score_valid)          r_score <= i_score;
      else if (r_cnt == TMO_LAST) r_score <= '0;
    end
  end

  bcd_split u_bcd (
    .i_bin  (r_credits),
    .o_tens (w_tens),
    .o_ones (w_ones)
  );

  assign o_credits      = r_credits;
  assign o_credits_tens = r_tens;
  assign o_credits_ones = r_ones;

endmodule

// File: tb/tb_credit_bank.sv
// Bench for credit_bank: directed transaction table, low-credit instance, async reset, random play.
module tb_credit_bank;
  import slot_pkg::*;

  localparam int HOLD  = 20;
  localparam int TMO   = 30;
  localparam int COST  = 1;
  localparam int MAXC  = 99;
  localparam int START = 10;

  logic                clk = 1'b0;
  logic                rst_n;
  logic                btn = 1'b0;
  logic [SCORE_W-1:0]  score = '0;
  logic                sv = 1'b0;
  logic                spin;
  logic [CREDIT_W-1:0] credits;
  logic [BCD_W-1:0]    tens;
  logic [BCD_W-1:0]    ones;
  logic                busy;
  logic                game_over;

  logic                l_btn = 1'b0;
  logic [SCORE_W-1:0]  l_score = '0;
  logic                l_sv = 1'b0;
  logic                l_spin;
  logic [CREDIT_W-1:0] l_cred;
  logic [BCD_W-1:0]    l_tens;
  logic [BCD_W-1:0]    l_ones;
  logic                l_busy;
  logic                l_over;

  int n_total = 0;
  int n_pass  = 0;
  int m_cred;
  bit m_over;

  always #5 clk = ~clk;

  credit_bank #(.START_CREDITS(START), .MAX_CREDITS(MAXC), .SPIN_COST(COST),
                .SPIN_HOLD(HOLD), .RESULT_TIMEOUT(TMO)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_spin_btn(btn), .i_score(score),
    .i_score_valid(sv), .o_spin(spin), .o_credits(credits),
    .o_credits_tens(tens), .o_credits_ones(ones), .o_busy(busy),
    .o_game_over(game_over));

  credit_bank #(.START_CREDITS(1), .MAX_CREDITS(MAXC), .SPIN_COST(COST),
                .SPIN_HOLD(HOLD), .RESULT_TIMEOUT(TMO)) u_low (
    .i_clk(clk), .i_rst_n(rst_n), .i_spin_btn(l_btn), .i_score(l_score),
    .i_score_valid(l_sv), .o_spin(l_spin), .o_credits(l_cred),
    .o_credits_tens(l_tens), .o_credits_ones(l_ones), .o_busy(l_busy),
    .o_game_over(l_over));

  typedef struct {
    int score;
    int dly;      // cycles after spin falls before score_valid; -1 = never (timeout)
    bit bounce;
    int exp_cred;
    int exp_tens;
    int exp_ones;
    bit exp_over;
  } vec_t;

  vec_t vecs[12];

  task automatic chk(input string nm, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
  endtask

  function automatic int ref_next(input int c, input int sc, input int dly);
    int n;
    n = c - COST + ((dly < 0) ? COST : sc);
    return (n > MAXC) ? MAXC : n;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_spin(input int sc, input int dly, input bit bounce,
                         input int exp_cred, input int exp_tens, input int exp_ones,
                         input bit exp_over);
    int pre;
    int cnt;
    int waitc;
    pre = m_cred;
    if (m_over) begin
      btn = 1'b1;
      repeat (6) tick();
      chk("over_spin", int'(spin), 0);
      chk("over_busy", int'(busy), 0);
      chk("over_flag", int'(game_over), 1);
      chk("over_cred", int'(credits), pre);
      btn = 1'b0;
      repeat (4) tick();
      return;
    end
    btn = 1'b1;
    tick();
    tick();
    chk("pre_busy", int'(busy), 0);
    tick();
    chk("charge_busy", int'(busy), 1);
    chk("charge_spin", int'(spin), 0);
    chk("charge_cred", int'(credits), pre);
    tick();
    chk("spin_rise", int'(spin), 1);
    chk("debit", int'(credits), pre - COST);
    cnt = 0;
    while (spin && cnt < HOLD + 5) begin
      cnt++;
      if (bounce) btn = (cnt < HOLD - 4 && cnt % 4 == 2) ? 1'b0 : 1'b1;
      tick();
    end
    chk("hold_len", cnt, HOLD);
    chk("one_debit", int'(credits), pre - COST);
    btn = 1'b0;
    if (dly >= 0) begin
      repeat (dly) tick();
      sv = 1'b1;
      score = SCORE_W'(sc);
      tick();
      sv = 1'b0;
      score = SCORE_W'($urandom_range(0, 15));
    end else begin
      score = SCORE_W'(sc);
    end
    waitc = 0;
    while (busy && waitc < TMO + 10) begin
      tick();
      waitc++;
    end
    chk("pay_latency", waitc, (dly >= 0) ? 1 : TMO + 1);
    chk("pay_cred", int'(credits), exp_cred);
    chk("pay_over", int'(game_over), int'(exp_over));
    chk("bcd_lag_tens", int'(tens), (pre - COST) / 10);
    chk("bcd_lag_ones", int'(ones), (pre - COST) % 10);
    tick();
    chk("bcd_tens", int'(tens), exp_tens);
    chk("bcd_ones", int'(ones), exp_ones);
    if (dly < 0) begin
      sv = 1'b1;
      score = 4'd15;
      tick();
      sv = 1'b0;
      tick();
      chk("late_sv_cred", int'(credits), exp_cred);
      chk("late_sv_busy", int'(busy), 0);
    end
    m_cred = exp_cred;
    m_over = exp_over;
    repeat (3) tick();
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int k;
    vecs[0]  = '{10, 2,       1'b1, 19, 1, 9, 1'b0};
    vecs[1]  = '{15, 0,       1'b0, 33, 3, 3, 1'b0};
    vecs[2]  = '{15, 5,       1'b1, 47, 4, 7, 1'b0};
    vecs[3]  = '{15, 1,       1'b0, 61, 6, 1, 1'b0};
    vecs[4]  = '{15, 7,       1'b0, 75, 7, 5, 1'b0};
    vecs[5]  = '{15, 0,       1'b0, 89, 8, 9, 1'b0};
    vecs[6]  = '{7,  TMO - 1, 1'b0, 95, 9, 5, 1'b0};
    vecs[7]  = '{10, 3,       1'b0, 99, 9, 9, 1'b0};
    vecs[8]  = '{12, -1,      1'b0, 99, 9, 9, 1'b0};
    vecs[9]  = '{0,  1,       1'b0, 98, 9, 8, 1'b0};
    vecs[10] = '{5,  -1,      1'b1, 98, 9, 8, 1'b0};
    vecs[11] = '{11, 4,       1'b0, 99, 9, 9, 1'b0};

    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    chk("rst_spin", int'(spin), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_over", int'(game_over), 0);
    chk("rst_cred", int'(credits), START);
    chk("rst_tens", int'(tens), 1);
    chk("rst_ones", int'(ones), 0);
    chk("low_rst_cred", int'(l_cred), 1);
    chk("low_rst_tens", int'(l_tens), 0);
    chk("low_rst_ones", int'(l_ones), 1);
    m_cred = START;
    m_over = 1'b0;

    // Single-credit instance: lose the last credit, then nothing but reset helps.
    l_btn = 1'b1;
    repeat (4) tick();
    chk("low_spin", int'(l_spin), 1);
    chk("low_debit", int'(l_cred), 0);
    l_btn = 1'b0;
    k = 0;
    while (l_spin && k < HOLD + 5) begin
      tick();
      k++;
    end
    l_sv = 1'b1;
    l_score = 4'd0;
    tick();
    l_sv = 1'b0;
    tick();
    chk("low_cred", int'(l_cred), 0);
    chk("low_over", int'(l_over), 1);
    chk("low_busy", int'(l_busy), 0);
    l_btn = 1'b1;
    repeat (6) tick();
    chk("low_repress_spin", int'(l_spin), 0);
    chk("low_repress_over", int'(l_over), 1);
    l_btn = 1'b0;
    l_sv = 1'b1;
    l_score = 4'd15;
    tick();
    l_sv = 1'b0;
    repeat (2) tick();
    chk("low_over_sv_cred", int'(l_cred), 0);
    chk("low_over_sv_busy", int'(l_busy), 0);

    for (int i = 0; i < 12; i++) begin
      do_spin(vecs[i].score, vecs[i].dly, vecs[i].bounce, vecs[i].exp_cred,
              vecs[i].exp_tens, vecs[i].exp_ones, vecs[i].exp_over);
    end

    // Reset in the middle of a spin must act without waiting for a clock edge.
    btn = 1'b1;
    repeat (8) tick();
    chk("mid_spin", int'(spin), 1);
    #2;
    rst_n = 1'b0;
    btn = 1'b0;
    #1;
    chk("arst_spin", int'(spin), 0);
    chk("arst_busy", int'(busy), 0);
    chk("arst_cred", int'(credits), START);
    chk("arst_over", int'(game_over), 0);
    chk("arst_low_over", int'(l_over), 0);
    chk("arst_low_cred", int'(l_cred), 1);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    chk("arst_tens", int'(tens), 1);
    chk("arst_ones", int'(ones), 0);
    chk("arst_idle", int'(busy), 0);
    m_cred = START;
    m_over = 1'b0;
    repeat (3) tick();

    for (int i = 0; i < 30; i++) begin
      int sc;
      int dly;
      int nc;
      bit bn;
      sc = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 3)) : 0;
      dly = ($urandom_range(0, 5) == 0) ? -1 : int'($urandom_range(0, TMO - 1));
      bn = 1'($urandom_range(0, 1));
      nc = m_over ? m_cred : ref_next(m_cred, sc, dly);
      do_spin(sc, dly, bn, nc, nc / 10, nc % 10, m_over || (nc < COST));
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/credit_bank.md
# credit_bank

Player-credit controller sitting directly upstream of the slot-machine core. It synchronises the raw spin button and charges one spin per press. It drives the core's `spin` level for the hold time the core requires, then consumes the core's final `score` and pays it back into the credit balance. The balance is presented in binary and as two registered BCD digits for the display stage; `game_over` latches when credits run out.

## Interface
- `START_CREDITS`, 10: balance loaded at reset (0..MAX_CREDITS).
- `MAX_CREDITS`, 99: saturation ceiling; must be ≤ 99 (two BCD digits).
- `SPIN_COST`, 1: credits charged per accepted spin (≥ 1).
- `SPIN_HOLD`, 4900: cycles `spin` is held high (7 s at 700 Hz).
- `RESULT_TIMEOUT`, 7000: cycles after `spin` falls to wait for `score_valid` before refunding.
- `clk`  in  1  system clock (700 Hz in the product build).
- `rst_n`  in  1  reset; one clock, asynchronous assert, active-low.
- `spin_btn`  in  1  raw spin button, asynchronous, active-high.
- `score`  in  4  payout from core, unsigned 0..15.
- `score_valid`  in  1  one-cycle strobe: `score` is final for the current spin.
- `spin`  out  1  spin request level to the core.
- `credits`  out  7  binary balance.
- `credits_tens`, `credits_ones`  out  4 each  BCD digits of `credits`.
- `busy`  out  1  high in any state other than IDLE and OVER.
- `game_over`  out  1  high in OVER.

## Operation
- Input path: 2-flop synchroniser on `spin_btn`, then a registered previous value.
- `press` = sync2 & ~prev, a single-cycle rising-edge pulse.
- State machine has five states: IDLE, CHARGE, SPINNING, AWAIT, PAYOUT. A sixth state, OVER, is terminal.
- IDLE:
  - `press` with credits ≥ SPIN_COST → CHARGE.
  - `press` with credits < SPIN_COST → OVER.
  - No press → stay in IDLE.
- CHARGE (1 cycle): credits ← credits − SPIN_COST; hold counter ← 0 → SPINNING.
- SPINNING: `spin` = 1; hold counter increments. When counter = SPIN_HOLD−1 → AWAIT, with the timeout counter cleared.
- AWAIT: `spin` = 0.
  - `score_valid` → latch `score` and go to PAYOUT.
  - Timeout counter reaching RESULT_TIMEOUT−1 → latch 0 and set refund flag → PAYOUT.
- PAYOUT (1 cycle): credits ← min(credits + payout, MAX_CREDITS). Payout is the latched score, or SPIN_COST if refund. Add at 8 bits, then saturate. Then:
  - resulting credits < SPIN_COST → OVER.
  - otherwise → IDLE.
- OVER: `game_over` = 1. All inputs are ignored; exit only via `rst_n`.
- `score_valid` is ignored in every state except AWAIT. `score_valid` in SPINNING does not shorten the hold.
- `press` is ignored in every state except IDLE. No queuing of presses.
- `score` values above 10 are accepted as-is; there is no clamping beyond MAX_CREDITS.

## Timing
- Reset values:
  - state IDLE; `spin` 0; `busy` 0; `game_over` 0.
  - `credits` = START_CREDITS; BCD digits = START_CREDITS split.
  - synchroniser and prev flops 0.
- `spin_btn` first sampled high at edge N gives `press` during cycle N+1→N+2. CHARGE is entered at N+2. `spin` = 1 and the debited `credits` are visible after N+3.
- `spin` is high for exactly SPIN_HOLD cycles.
- The `credits` update happens at the PAYOUT edge. BCD digits follow `credits` one cycle later, since they are registered.
- `busy` is a combinational decode of the state and rises with CHARGE.
- `rst_n` low mid-spin drops `spin` immediately (asynchronously) and restores START_CREDITS. No refund bookkeeping is carried over.
- `score_valid` and the final timeout cycle coinciding: the score wins, with no refund.

## Structure
- Shared package `slot_pkg` holds:
  - state enum `bank_state_t`.
  - constants `SCORE_W` = 4, `CREDIT_W` = 7, `BCD_W` = 4.
  - payout values `PAY_NONE` = 0, `PAY_PAIR` = 1, `PAY_TRIPLE` = 5, `PAY_QUAD` = 10.
- One sub-module, `bcd_split`: combinational 7-bit (0..99) → tens/ones. Its outputs are registered in `credit_bank`.

## Test plan
- Reset, then press once and return score 10 via `score_valid`. Required: credits 10→9 at CHARGE, then 19 after PAYOUT; BCD reads 1/9 one cycle later.
- Press held across SPIN_HOLD, with bounce pulses applied during SPINNING. Required: `spin` is high for exactly SPIN_HOLD cycles, only one debit occurs, and the extra edges are ignored.
- START_CREDITS = 1, press, score 0. Required: credits 0 and `game_over` = 1 after PAYOUT. A further press has no effect until `rst_n`.
- Credits 95, score 10. Required: credits saturate at 99 and the BCD digits read 9/9.
- No `score_valid` after the spin. Required: after RESULT_TIMEOUT cycles the cost is refunded (credits back to the pre-spin value), and a `score_valid` arriving later is ignored in IDLE.
- `rst_n` pulsed low mid-SPINNING. Required: `spin` falls asynchronously, credits = START_CREDITS, state IDLE, `game_over` = 0.
